// File: rtl/ps2_key_event_ctrl_if.sv
// Byte-in / event-out bundle for the PS/2 key event controller.
// The slave modport is the controller side; the master modport is the receiver/consumer side.
interface ps2_key_event_ctrl_if #(
    parameter int unsigned DEPTH = 8
);
    logic [7:0]             scancode_in;
    logic                   valid_in;
    logic                   error_in;
    logic [9:0]             event_out;
    logic                   event_valid_out;
    logic                   event_ready_in;
    logic                   overflow_out;
    logic [$clog2(DEPTH):0] count_out;

    modport master (
        output scancode_in, valid_in, error_in, event_ready_in,
        input  event_out, event_valid_out, overflow_out, count_out
    );

    modport slave (
        input  scancode_in, valid_in, error_in, event_ready_in,
        output event_out, event_valid_out, overflow_out, count_out
    );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// Decodes the PS/2 E0/F0/E1 prefix grammar into {ext, brk, code} events
// and queues them in a show-ahead ready/valid FIFO with sticky overflow.
module ps2_key_event_ctrl #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input logic                 clk_in,
    input logic                 rst_in,
    ps2_key_event_ctrl_if.slave bus_io
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StPause} state_e;

    state_e        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push;
    logic [9:0]    push_data;

    logic [7:0] code;
    logic       accept, is_prefix, is_status;

    assign code      = bus_io.scancode_in;
    assign accept    = bus_io.valid_in & ~bus_io.error_in;
    assign is_prefix = (code == 8'hE0) || (code == 8'hE1) || (code == 8'hF0);
    assign is_status = (code == 8'hFA) || (code == 8'hAA) || (code == 8'hEE) ||
                       (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            skip_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        tmo_d     = tmo_q;
        push      = 1'b0;
        push_data = '0;
        if (bus_io.error_in) begin
            state_d = StIdle;
            skip_d  = '0;
            tmo_d   = '0;
        end else if (accept) begin
            tmo_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (code == 8'hE0) begin
                        state_d = StExt;
                    end else if (code == 8'hF0) begin
                        state_d = StBrk;
                    end else if (code == 8'hE1) begin
                        state_d = StPause;
                        skip_d  = 3'd7;
                    end else if (!is_status) begin
                        push      = 1'b1;
                        push_data = {2'b00, code};
                    end
                end
                StExt: begin
                    if (code == 8'hF0) begin
                        state_d = StExtBrk;
                    end else if (code != 8'hE0 && code != 8'hE1) begin
                        push      = 1'b1;
                        push_data = {2'b10, code};
                        state_d   = StIdle;
                    end
                end
                StBrk: begin
                    state_d   = StIdle;
                    push      = !is_prefix;
                    push_data = {2'b01, code};
                end
                StExtBrk: begin
                    state_d   = StIdle;
                    push      = !is_prefix;
                    push_data = {2'b11, code};
                end
                StPause: begin
                    skip_d = skip_q - 3'd1;
                    // The pause key reports a single make event once its tail is consumed
                    if (skip_q == 3'd1) begin
                        push      = 1'b1;
                        push_data = {2'b10, 8'hE1};
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = StIdle;
                skip_d  = '0;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          pop, push_ok;

    assign pop     = (count_q != '0) & bus_io.event_ready_in;
    // A full FIFO still takes a push when the head leaves on the same edge
    assign push_ok = push & ((count_q != Full) | pop);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) tail_q <= tail_q + AW'(1);
            if (pop)     head_q <= head_q + AW'(1);
            if (push_ok && !pop)      count_q <= count_q + (AW + 1)'(1);
            else if (pop && !push_ok) count_q <= count_q - (AW + 1)'(1);
            if (push && !push_ok)     ovf_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) mem_q[tail_q] <= push_data;
    end

    assign bus_io.event_out       = mem_q[head_q];
    assign bus_io.event_valid_out = (count_q != '0);
    assign bus_io.count_out       = count_q;
    assign bus_io.overflow_out    = ovf_q;
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: vector table for decode, hand sequences
// for timeout, overflow, full push-with-pop and reset.
module tb_ps2_key_event_ctrl;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_event_ctrl_if #(.DEPTH(DEPTH)) bus ();

    ps2_key_event_ctrl #(
        .DEPTH         (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus_io(bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] code;
        logic       v;
        logic       e;
        logic       exp_v;
        logic [9:0] exp_ev;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of input at a negedge; returns at the next negedge
    task automatic send(input logic [7:0] b, input logic v, input logic e);
        bus.scancode_in = b;
        bus.valid_in    = v;
        bus.error_in    = e;
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.error_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.scancode_in = 8'h1C;
        bus.valid_in    = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.valid_in = 1'b0;
    endtask

    initial begin
        bus.scancode_in    = '0;
        bus.valid_in       = 1'b0;
        bus.error_in       = 1'b0;
        bus.event_ready_in = 1'b0;
        idle(2);
        rst = 1'b0;
        chk("reset count", 32'(bus.count_out), 0);
        chk("reset valid", 32'(bus.event_valid_out), 0);
        chk("reset overflow", 32'(bus.overflow_out), 0);

        // Decode table with ready held high: each pushed event is visible for exactly one cycle
        vecs.push_back(vec_t'{8'h1C, 1'b1, 1'b0, 1'b1, 10'h01C});
        vecs.push_back(vec_t'{8'hF0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h1C, 1'b1, 1'b0, 1'b1, 10'h11C});
        vecs.push_back(vec_t'{8'hE0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h75, 1'b1, 1'b0, 1'b1, 10'h275});
        vecs.push_back(vec_t'{8'hE0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hF0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h75, 1'b1, 1'b0, 1'b1, 10'h375});
        vecs.push_back(vec_t'{8'hAA, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hFA, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hEE, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hFE, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h00, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hFF, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hE1, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h14, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h77, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hE1, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hF0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h14, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hF0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h77, 1'b1, 1'b0, 1'b1, 10'h2E1});
        vecs.push_back(vec_t'{8'hE0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hF0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h75, 1'b1, 1'b1, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h75, 1'b1, 1'b0, 1'b1, 10'h075});
        vecs.push_back(vec_t'{8'hE0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h00, 1'b0, 1'b1, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h75, 1'b1, 1'b0, 1'b1, 10'h075});
        vecs.push_back(vec_t'{8'h75, 1'b1, 1'b1, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hE0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hE0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h74, 1'b1, 1'b0, 1'b1, 10'h274});
        vecs.push_back(vec_t'{8'hF0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hE0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h12, 1'b1, 1'b0, 1'b1, 10'h012});
        vecs.push_back(vec_t'{8'hE0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hF0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hF0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h12, 1'b1, 1'b0, 1'b1, 10'h012});

        bus.event_ready_in = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].code, vecs[i].v, vecs[i].e);
            chk($sformatf("vec%0d valid", i), 32'(bus.event_valid_out), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v)
                chk($sformatf("vec%0d event", i), 32'(bus.event_out), 32'(vecs[i].exp_ev));
        end
        idle(1);
        chk("table drained count", 32'(bus.count_out), 0);

        // Timeout: a full TIMEOUT_CYCLES gap abandons E0, one cycle less does not
        send(8'hE0, 1'b1, 1'b0);
        idle(TMO);
        send(8'h1C, 1'b1, 1'b0);
        chk("timeout valid", 32'(bus.event_valid_out), 1);
        chk("timeout event", 32'(bus.event_out), 32'h01C);
        idle(1);
        send(8'hE0, 1'b1, 1'b0);
        idle(TMO - 1);
        send(8'h1C, 1'b1, 1'b0);
        chk("pre-timeout event", 32'(bus.event_out), 32'h21C);
        idle(1);
        chk("pre-timeout drained", 32'(bus.event_valid_out), 0);

        // Overflow with consumer stalled
        bus.event_ready_in = 1'b0;
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b1, 1'b0);
        chk("ovf count", 32'(bus.count_out), 8);
        chk("ovf flag", 32'(bus.overflow_out), 1);
        chk("ovf valid", 32'(bus.event_valid_out), 1);
        chk("ovf head", 32'(bus.event_out), 32'h001);
        bus.event_ready_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d", i), 32'(bus.event_out), 32'(i));
            @(negedge clk);
        end
        chk("drain empty", 32'(bus.event_valid_out), 0);
        chk("drain count", 32'(bus.count_out), 0);
        chk("ovf sticky", 32'(bus.overflow_out), 1);

        do_reset();
        chk("rst ovf clear", 32'(bus.overflow_out), 0);
        chk("rst ignores valid", 32'(bus.count_out), 0);

        // Push coincident with pop while full
        bus.event_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b1, 1'b0);
        chk("full count", 32'(bus.count_out), 8);
        bus.event_ready_in = 1'b1;
        send(8'h18, 1'b1, 1'b0);
        chk("full push+pop count", 32'(bus.count_out), 8);
        chk("full push+pop ovf", 32'(bus.overflow_out), 0);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("fulldrain%0d", i), 32'(bus.event_out), 32'h10 + 32'(i));
            @(negedge clk);
        end
        chk("fulldrain empty", 32'(bus.event_valid_out), 0);

        // Reset mid-EXT with three queued events
        bus.event_ready_in = 1'b0;
        send(8'h21, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        send(8'h23, 1'b1, 1'b0);
        send(8'hE0, 1'b1, 1'b0);
        chk("pre-reset count", 32'(bus.count_out), 3);
        do_reset();
        chk("post-reset count", 32'(bus.count_out), 0);
        chk("post-reset valid", 32'(bus.event_valid_out), 0);
        chk("post-reset ovf", 32'(bus.overflow_out), 0);
        send(8'h1C, 1'b1, 1'b0);
        chk("post-reset valid2", 32'(bus.event_valid_out), 1);
        chk("post-reset event", 32'(bus.event_out), 32'h01C);
        chk("post-reset count2", 32'(bus.count_out), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
